// File: rtl/wb_cmd_master.sv
// -----------------------------------------------------------------------------
// wb_cmd_master
// Turns one command at a time into a single Wishbone classic cycle and returns
// a response (read data or zero, plus a timeout error flag). A command is
// accepted in IDLE, driven on the bus in BUS until ACK or timeout, and held in
// RESP until the consumer takes it. Every output comes straight from a flop.
//
// Ports
//   WB_CLK, WB_RSTn          clock (rising edge) / async active-low reset
//   CMD_VALID_i/CMD_READY_o  command handshake
//   CMD_WE_i, CMD_ADR_i, CMD_BYTE_STB_i, CMD_WR_DAT_i   command fields
//   RSP_VALID_o/RSP_READY_i  response handshake
//   RSP_RD_DAT_o, RSP_ERR_o  response data and timeout flag
//   WBs_ADR, WBs_CYC, WBs_STB, WBs_WE, WBs_RD, WBs_BYTE_STB, WBs_WR_DAT
//                            Wishbone initiator outputs
//   WBs_RD_DAT, WBs_ACK      Wishbone client responses
//   BUSY_o                   high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module wb_cmd_master #(
  parameter int ADR_WIDTH      = 17,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RSTn,
  input  logic                 CMD_VALID_i,
  output logic                 CMD_READY_o,
  input  logic                 CMD_WE_i,
  input  logic [ADR_WIDTH-1:0] CMD_ADR_i,
  input  logic [3:0]           CMD_BYTE_STB_i,
  input  logic [31:0]          CMD_WR_DAT_i,
  output logic                 RSP_VALID_o,
  input  logic                 RSP_READY_i,
  output logic [31:0]          RSP_RD_DAT_o,
  output logic                 RSP_ERR_o,
  output logic [ADR_WIDTH-1:0] WBs_ADR,
  output logic                 WBs_CYC,
  output logic                 WBs_STB,
  output logic                 WBs_WE,
  output logic                 WBs_RD,
  output logic [3:0]           WBs_BYTE_STB,
  output logic [31:0]          WBs_WR_DAT,
  input  logic [31:0]          WBs_RD_DAT,
  input  logic                 WBs_ACK,
  output logic                 BUSY_o
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_e;

  // Last wait-count value before the abort fires; with TIMEOUT_CYCLES=N the
  // bus stays up for exactly N cycles when no ACK arrives.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [15:0]            waitCnt_q, waitCnt_d;
  logic                   cmdReady_q, cmdReady_d;
  logic                   busy_q, busy_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic                   rd_q, rd_d;
  logic [ADR_WIDTH-1:0]   adr_q, adr_d;
  logic [3:0]             byteStb_q, byteStb_d;
  logic [31:0]            wrDat_q, wrDat_d;
  logic                   rspValid_q, rspValid_d;
  logic [31:0]            rspDat_q, rspDat_d;
  logic                   rspErr_q, rspErr_d;

  logic accept;
  logic timeoutHit;

  assign accept     = CMD_VALID_i && cmdReady_q;
  assign timeoutHit = (waitCnt_q == TMO_LAST);

  // State and output registers; reset clears everything, including the
  // ready flag, which comes up one cycle after reset release.
  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      state_q    <= IDLE;
      waitCnt_q  <= '0;
      cmdReady_q <= 1'b0;
      busy_q     <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      rd_q       <= 1'b0;
      adr_q      <= '0;
      byteStb_q  <= '0;
      wrDat_q    <= '0;
      rspValid_q <= 1'b0;
      rspDat_q   <= '0;
      rspErr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      waitCnt_q  <= waitCnt_d;
      cmdReady_q <= cmdReady_d;
      busy_q     <= busy_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      rd_q       <= rd_d;
      adr_q      <= adr_d;
      byteStb_q  <= byteStb_d;
      wrDat_q    <= wrDat_d;
      rspValid_q <= rspValid_d;
      rspDat_q   <= rspDat_d;
      rspErr_q   <= rspErr_d;
    end
  end

  // Next-state logic. ACK is checked before the timeout so a coincident ACK
  // still completes the transfer successfully.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = BUS;
      BUS:     if (WBs_ACK || timeoutHit) state_d = RESP;
      RESP:    if (RSP_READY_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output/datapath next values, computed one cycle ahead so that every
  // output is a flop.
  always_comb begin
    waitCnt_d  = waitCnt_q;
    cmdReady_d = cmdReady_q;
    busy_d     = busy_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    rd_d       = rd_q;
    adr_d      = adr_q;
    byteStb_d  = byteStb_q;
    wrDat_d    = wrDat_q;
    rspValid_d = rspValid_q;
    rspDat_d   = rspDat_q;
    rspErr_d   = rspErr_q;
    unique case (state_q)
      IDLE: begin
        cmdReady_d = 1'b1;
        if (accept) begin
          cmdReady_d = 1'b0;
          busy_d     = 1'b1;
          cyc_d      = 1'b1;
          we_d       = CMD_WE_i;
          rd_d       = ~CMD_WE_i;
          adr_d      = CMD_ADR_i;
          byteStb_d  = CMD_BYTE_STB_i;
          wrDat_d    = CMD_WR_DAT_i;
          waitCnt_d  = '0;
        end
      end
      BUS: begin
        if (WBs_ACK || timeoutHit) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          rd_d       = 1'b0;
          rspValid_d = 1'b1;
          rspErr_d   = ~WBs_ACK;
          rspDat_d   = (WBs_ACK && !we_q) ? WBs_RD_DAT : 32'h0;
        end else begin
          waitCnt_d = waitCnt_q + 16'd1;
        end
      end
      RESP: begin
        if (RSP_READY_i) begin
          rspValid_d = 1'b0;
          cmdReady_d = 1'b1;
          busy_d     = 1'b0;
        end
      end
      default: begin
        cmdReady_d = 1'b0;
      end
    endcase
  end

  assign CMD_READY_o  = cmdReady_q;
  assign BUSY_o       = busy_q;
  assign WBs_CYC      = cyc_q;
  assign WBs_STB      = cyc_q;
  assign WBs_WE       = we_q;
  assign WBs_RD       = rd_q;
  assign WBs_ADR      = adr_q;
  assign WBs_BYTE_STB = byteStb_q;
  assign WBs_WR_DAT   = wrDat_q;
  assign RSP_VALID_o  = rspValid_q;
  assign RSP_RD_DAT_o = rspDat_q;
  assign RSP_ERR_o    = rspErr_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_wb_cmd_master
// Directed bench for wb_cmd_master with TIMEOUT_CYCLES=4: read, timeout with
// response backpressure, write with immediate ACK, ACK coincident with the
// timeout cycle, and reset asserted in the middle of a bus cycle.
// -----------------------------------------------------------------------------
module tb_wb_cmd_master;

  localparam int AW = 17;

  logic          WB_CLK = 1'b0;
  logic          WB_RSTn;
  logic          CMD_VALID_i;
  logic          CMD_READY_o;
  logic          CMD_WE_i;
  logic [AW-1:0] CMD_ADR_i;
  logic [3:0]    CMD_BYTE_STB_i;
  logic [31:0]   CMD_WR_DAT_i;
  logic          RSP_VALID_o;
  logic          RSP_READY_i;
  logic [31:0]   RSP_RD_DAT_o;
  logic          RSP_ERR_o;
  logic [AW-1:0] WBs_ADR;
  logic          WBs_CYC;
  logic          WBs_STB;
  logic          WBs_WE;
  logic          WBs_RD;
  logic [3:0]    WBs_BYTE_STB;
  logic [31:0]   WBs_WR_DAT;
  logic [31:0]   WBs_RD_DAT;
  logic          WBs_ACK;
  logic          BUSY_o;

  int checkCount = 0;
  int passCount  = 0;

  wb_cmd_master #(.ADR_WIDTH(AW), .TIMEOUT_CYCLES(4)) dut (
    .WB_CLK(WB_CLK), .WB_RSTn(WB_RSTn),
    .CMD_VALID_i(CMD_VALID_i), .CMD_READY_o(CMD_READY_o),
    .CMD_WE_i(CMD_WE_i), .CMD_ADR_i(CMD_ADR_i),
    .CMD_BYTE_STB_i(CMD_BYTE_STB_i), .CMD_WR_DAT_i(CMD_WR_DAT_i),
    .RSP_VALID_o(RSP_VALID_o), .RSP_READY_i(RSP_READY_i),
    .RSP_RD_DAT_o(RSP_RD_DAT_o), .RSP_ERR_o(RSP_ERR_o),
    .WBs_ADR(WBs_ADR), .WBs_CYC(WBs_CYC), .WBs_STB(WBs_STB),
    .WBs_WE(WBs_WE), .WBs_RD(WBs_RD), .WBs_BYTE_STB(WBs_BYTE_STB),
    .WBs_WR_DAT(WBs_WR_DAT), .WBs_RD_DAT(WBs_RD_DAT), .WBs_ACK(WBs_ACK),
    .BUSY_o(BUSY_o)
  );

  always #5 WB_CLK = ~WB_CLK;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge WB_CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic we,
                               input logic [AW-1:0] adr, input logic [3:0] stb,
                               input logic [31:0] dat);
    CMD_VALID_i    = valid;
    CMD_WE_i       = we;
    CMD_ADR_i      = adr;
    CMD_BYTE_STB_i = stb;
    CMD_WR_DAT_i   = dat;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  initial begin
    WB_RSTn     = 1'b0;
    RSP_READY_i = 1'b0;
    WBs_ACK     = 1'b0;
    WBs_RD_DAT  = 32'h0;
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0);

    // Reset state
    #3;
    checkOutput("rst_ready", CMD_READY_o, 0);
    checkOutput("rst_busy", BUSY_o, 0);
    checkOutput("rst_cyc", WBs_CYC, 0);
    checkOutput("rst_rspvalid", RSP_VALID_o, 0);
    checkOutput("rst_adr", WBs_ADR, 0);
    #9 WB_RSTn = 1'b1;
    tick();
    checkOutput("rel_ready", CMD_READY_o, 1);

    // Read, ACK on second BUS cycle
    applyStimulus(1'b1, 1'b0, 17'h00100, 4'hF, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0);
    checkOutput("rd_cyc1", WBs_CYC, 1);
    checkOutput("rd_stb1", WBs_STB, 1);
    checkOutput("rd_rd1", WBs_RD, 1);
    checkOutput("rd_we1", WBs_WE, 0);
    checkOutput("rd_adr", WBs_ADR, 32'h00100);
    checkOutput("rd_bstb", WBs_BYTE_STB, 4'hF);
    checkOutput("rd_ready", CMD_READY_o, 0);
    checkOutput("rd_busy", BUSY_o, 1);
    tick();
    checkOutput("rd_cyc2", WBs_CYC, 1);
    checkOutput("rd_rd2", WBs_RD, 1);
    WBs_ACK    = 1'b1;
    WBs_RD_DAT = 32'hA5A5_1234;
    tick();
    WBs_ACK    = 1'b0;
    WBs_RD_DAT = 32'h0;
    checkOutput("rd_cyc_drop", WBs_CYC, 0);
    checkOutput("rd_rd_drop", WBs_RD, 0);
    checkOutput("rd_rspvalid", RSP_VALID_o, 1);
    checkOutput("rd_data", RSP_RD_DAT_o, 32'hA5A5_1234);
    checkOutput("rd_err", RSP_ERR_o, 0);
    RSP_READY_i = 1'b1;
    tick();
    RSP_READY_i = 1'b0;
    checkOutput("rd_done_valid", RSP_VALID_o, 0);
    checkOutput("rd_done_ready", CMD_READY_o, 1);
    checkOutput("rd_done_busy", BUSY_o, 0);

    // Timeout: no ACK, CYC up exactly 4 cycles
    applyStimulus(1'b1, 1'b0, 17'h00055, 4'h1, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("tmo_cyc%0d", i + 1), WBs_CYC, 1);
      tick();
    end
    checkOutput("tmo_cyc_drop", WBs_CYC, 0);
    checkOutput("tmo_rspvalid", RSP_VALID_o, 1);
    checkOutput("tmo_err", RSP_ERR_o, 1);
    checkOutput("tmo_data", RSP_RD_DAT_o, 32'h0);

    // Backpressure: next write offered while response is held for 5 cycles;
    // ACK is also held high here and must be ignored outside BUS.
    applyStimulus(1'b1, 1'b1, 17'h00004, 4'h3, 32'hCAFE_F00D);
    WBs_ACK = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("bp_valid%0d", i), RSP_VALID_o, 1);
      checkOutput($sformatf("bp_err%0d", i), RSP_ERR_o, 1);
      checkOutput($sformatf("bp_ready%0d", i), CMD_READY_o, 0);
      checkOutput($sformatf("bp_cyc%0d", i), WBs_CYC, 0);
    end
    RSP_READY_i = 1'b1;
    tick();
    RSP_READY_i = 1'b0;
    checkOutput("bp_done_valid", RSP_VALID_o, 0);
    checkOutput("bp_done_ready", CMD_READY_o, 1);
    checkOutput("bp_done_cyc", WBs_CYC, 0);

    // Write accepted now, immediate ACK
    tick();
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0);
    checkOutput("wr_cyc", WBs_CYC, 1);
    checkOutput("wr_we", WBs_WE, 1);
    checkOutput("wr_rd", WBs_RD, 0);
    checkOutput("wr_adr", WBs_ADR, 32'h00004);
    checkOutput("wr_dat", WBs_WR_DAT, 32'hCAFE_F00D);
    checkOutput("wr_bstb", WBs_BYTE_STB, 4'h3);
    tick();
    WBs_ACK = 1'b0;
    checkOutput("wr_cyc_drop", WBs_CYC, 0);
    checkOutput("wr_we_drop", WBs_WE, 0);
    checkOutput("wr_rspvalid", RSP_VALID_o, 1);
    checkOutput("wr_data", RSP_RD_DAT_o, 32'h0);
    checkOutput("wr_err", RSP_ERR_o, 0);
    RSP_READY_i = 1'b1;
    tick();
    RSP_READY_i = 1'b0;
    checkOutput("wr_done_valid", RSP_VALID_o, 0);

    // ACK coincident with the timeout cycle
    applyStimulus(1'b1, 1'b0, 17'h1FFFF, 4'hC, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0);
    tick();
    tick();
    tick();
    checkOutput("co_cyc4", WBs_CYC, 1);
    WBs_ACK    = 1'b1;
    WBs_RD_DAT = 32'h1357_9BDF;
    tick();
    WBs_ACK    = 1'b0;
    WBs_RD_DAT = 32'h0;
    checkOutput("co_rspvalid", RSP_VALID_o, 1);
    checkOutput("co_err", RSP_ERR_o, 0);
    checkOutput("co_data", RSP_RD_DAT_o, 32'h1357_9BDF);
    RSP_READY_i = 1'b1;
    tick();
    RSP_READY_i = 1'b0;

    // Reset pulse in the middle of BUS
    applyStimulus(1'b1, 1'b0, 17'h00020, 4'hF, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0);
    checkOutput("rb_cyc", WBs_CYC, 1);
    tick();
    #2 WB_RSTn = 1'b0;
    #1;
    checkOutput("rb_cyc_async", WBs_CYC, 0);
    checkOutput("rb_stb_async", WBs_STB, 0);
    checkOutput("rb_ready_async", CMD_READY_o, 0);
    checkOutput("rb_busy_async", BUSY_o, 0);
    #2 WB_RSTn = 1'b1;
    tick();
    checkOutput("rb_rel_ready", CMD_READY_o, 1);
    checkOutput("rb_rel_valid", RSP_VALID_o, 0);
    tick();
    checkOutput("rb_no_rsp", RSP_VALID_o, 0);
    checkOutput("rb_idle_cyc", WBs_CYC, 0);

    // Command after reset completes normally
    applyStimulus(1'b1, 1'b0, 17'h00040, 4'hF, 32'h0);
    tick();
    applyStimulus(1'b0, 1'b0, '0, 4'h0, 32'h0);
    checkOutput("pr_cyc", WBs_CYC, 1);
    checkOutput("pr_adr", WBs_ADR, 32'h00040);
    WBs_ACK    = 1'b1;
    WBs_RD_DAT = 32'hDEAD_BEEF;
    tick();
    WBs_ACK    = 1'b0;
    WBs_RD_DAT = 32'h0;
    checkOutput("pr_rspvalid", RSP_VALID_o, 1);
    checkOutput("pr_data", RSP_RD_DAT_o, 32'hDEAD_BEEF);
    checkOutput("pr_err", RSP_ERR_o, 0);
    RSP_READY_i = 1'b1;
    tick();
    RSP_READY_i = 1'b0;
    checkOutput("pr_done_ready", CMD_READY_o, 1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/wb_cmd_master.md
WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 17, Wishbone address width.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, BUS-state cycles without ACK before abort; legal range 2..65535.
REQ-003 SHALL have WB_CLK  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have WB_RSTn  input  1  asynchronous active-low reset.
REQ-005 SHALL have CMD_VALID_i  input  1  command offered.
REQ-006 SHALL have CMD_READY_o  output  1  command accepted when high with CMD_VALID_i.
REQ-007 SHALL have CMD_WE_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have CMD_ADR_i  input  ADR_WIDTH  target address.
REQ-009 SHALL have CMD_BYTE_STB_i  input  4  byte enables.
REQ-010 SHALL have CMD_WR_DAT_i  input  32  write data.
REQ-011 SHALL have RSP_VALID_o  output  1  response available.
REQ-012 SHALL have RSP_READY_i  input  1  response consumed when high with RSP_VALID_o.
REQ-013 SHALL have RSP_RD_DAT_o  output  32  read data.
REQ-014 SHALL have RSP_ERR_o  output  1  1 = transaction timed out.
REQ-015 SHALL have WBs_ADR  output  ADR_WIDTH; WBs_CYC, WBs_STB, WBs_WE, WBs_RD  output  1 each; WBs_BYTE_STB  output  4; WBs_WR_DAT  output  32 -- Wishbone initiator signals.
REQ-016 SHALL have WBs_RD_DAT  input  32  and  WBs_ACK  input  1  -- client responses.
REQ-017 SHALL have BUSY_o  output  1  high in any state other than IDLE.

Function
REQ-018 SHALL implement FSM IDLE -> BUS -> RESP -> IDLE; all outputs registered.
REQ-019 IDLE: CMD_READY_o=1; on CMD_VALID_i&CMD_READY_o at edge N, SHALL latch command, go BUS, drive WBs_CYC=WBs_STB=1 from cycle N+1.
REQ-020 BUS: WBs_WE=CMD_WE, WBs_RD=~CMD_WE, WBs_ADR/BYTE_STB/WR_DAT = latched values, all stable until exit; CMD_READY_o=0.
REQ-021 ACK sampled high in BUS at edge M SHALL: capture WBs_RD_DAT (reads) or 32'h0 (writes) into RSP_RD_DAT_o, RSP_ERR_o=0, drop CYC/STB/WE/RD, assert RSP_VALID_o, all from cycle M+1; go RESP.
REQ-022 16-bit wait counter SHALL clear on BUS entry, increment each BUS cycle with ACK low; when it equals TIMEOUT_CYCLES-1 with ACK low, SHALL abort: RSP_RD_DAT_o=32'h0, RSP_ERR_o=1, bus signals dropped, go RESP.
REQ-023 ACK and timeout condition in same cycle: ACK wins, RSP_ERR_o=0.
REQ-024 Writes SHALL also return a response (ERR reporting).
REQ-025 RESP: RSP_VALID_o, RSP_RD_DAT_o, RSP_ERR_o held stable until RSP_READY_i sampled high; then RSP_VALID_o=0, CMD_READY_o=1 next cycle, go IDLE.
REQ-026 WBs_ACK outside BUS SHALL be ignored; CMD_VALID_i outside IDLE SHALL be ignored.
REQ-027 Minimum throughput: one transaction per 3 cycles (accept, 1-cycle ACK, 1-cycle RESP with RSP_READY_i high).

Reset
REQ-028 WB_RSTn low SHALL immediately force IDLE, counter 0, CMD_READY_o=0 while asserted then 1 first cycle after release, all other outputs 0 (WBs_* buses 0, RSP_* 0, BUSY_o 0).
REQ-029 Reset mid-BUS or mid-RESP SHALL drop CYC/STB and RSP_VALID_o asynchronously; the pending command is discarded with no response.

Verification
REQ-030 Read: cmd WE=0 ADR=17'h00100 BYTE_STB=4'hF; client ACKs 2nd BUS cycle with RD_DAT=32'hA5A5_1234 -> CYC/STB/RD high 2 cycles, RSP_RD_DAT_o=32'hA5A5_1234, RSP_ERR_o=0.
REQ-031 Write: WE=1 ADR=17'h00004 WR_DAT=32'hCAFE_F00D BYTE_STB=4'h3, immediate ACK -> bus fields match for exactly 1 cycle with WE=1 RD=0; response DAT=0 ERR=0.
REQ-032 Timeout: TIMEOUT_CYCLES=4, ACK never -> CYC high exactly 4 cycles, RSP_ERR_o=1, DAT=0.
REQ-033 ACK coincident with timeout cycle (TIMEOUT_CYCLES=4, ACK on 4th cycle) -> ERR=0, data captured.
REQ-034 Backpressure: RSP_READY_i low 5 cycles with CMD_VALID_i held high -> RSP held stable, CMD_READY_o=0, second command accepted only after RSP handshake.
REQ-035 WB_RSTn pulsed low mid-BUS -> CYC/STB 0 same cycle, no RSP_VALID_o, next command completes normally.
